// File: rtl/dram_arbiter.sv
// Round-robin arbiter letting N_CORES cores share one single-port data RAM.
// Every access walks IDLE -> ISSUE -> CAPTURE -> DONE; the RAM read has one cycle of latency.
module dram_arbiter #(
    parameter int N_CORES = 4,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_CORES-1:0]         core_req,
    input  logic [N_CORES-1:0]         core_wr,
    input  logic [N_CORES*ADDR_W-1:0]  core_addr,
    input  logic [N_CORES*DATA_W-1:0]  core_wdata,
    output logic [N_CORES*DATA_W-1:0]  core_rdata,
    output logic [N_CORES-1:0]         core_ack,
    output logic [N_CORES-1:0]         core_status,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    output logic                       mem_wr_en,
    input  logic [DATA_W-1:0]          mem_rdata,
    output logic [15:0]                access_count
);
    localparam int IDX_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                      state_q, state_d;
    logic [IDX_W-1:0]            rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]            grant_q, grant_d;
    logic                        wr_q, wr_d;
    logic [N_CORES-1:0]          mask_q, mask_d;
    logic [N_CORES-1:0]          core_ack_q, core_ack_d;
    logic [N_CORES*DATA_W-1:0]   core_rdata_q, core_rdata_d;
    logic [ADDR_W-1:0]           mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]           mem_wdata_q, mem_wdata_d;
    logic                        mem_wr_en_q, mem_wr_en_d;
    logic [15:0]                 access_count_q, access_count_d;

    logic [N_CORES-1:0]          eligible_s;
    logic [IDX_W-1:0]            cand_s;
    logic [IDX_W-1:0]            pick_s;
    logic                        found_s;

    // Round-robin pick: first eligible core at or after rr_ptr, wrapping around.
    // The core just served is masked for the single IDLE cycle after its DONE.
    always_comb begin
        eligible_s = core_req & ~mask_q;
        found_s    = 1'b0;
        pick_s     = '0;
        cand_s     = '0;
        for (int k = 0; k < N_CORES; k++) begin
            cand_s = IDX_W'((int'(rr_ptr_q) + k) % N_CORES);
            if (!found_s && eligible_s[cand_s]) begin
                found_s = 1'b1;
                pick_s  = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Access sequencing: next state and next value of every registered output.
    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        grant_d        = grant_q;
        wr_d           = wr_q;
        mask_d         = mask_q;
        core_ack_d     = '0;
        core_rdata_d   = core_rdata_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        mem_wr_en_d    = 1'b0;
        access_count_d = access_count_q;
        case (state_q)
            IDLE: begin
                mask_d = '0;
                if (found_s) begin
                    grant_d     = pick_s;
                    wr_d        = core_wr[pick_s];
                    mem_addr_d  = core_addr[int'(pick_s) * ADDR_W +: ADDR_W];
                    mem_wdata_d = core_wdata[int'(pick_s) * DATA_W +: DATA_W];
                    mem_wr_en_d = core_wr[pick_s];
                    state_d     = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                if (!wr_q) begin
                    core_rdata_d[int'(grant_q) * DATA_W +: DATA_W] = mem_rdata;
                end else begin
                    core_rdata_d = core_rdata_q;
                end
                core_ack_d[grant_q] = 1'b1;
                state_d             = DONE;
            end
            DONE: begin
                rr_ptr_d          = (grant_q == IDX_W'(N_CORES - 1)) ? '0 : grant_q + IDX_W'(1);
                mask_d            = '0;
                mask_d[grant_q]   = 1'b1;
                access_count_d    = access_count_q + 16'd1;
                state_d           = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            rr_ptr_q       <= '0;
            grant_q        <= '0;
            wr_q           <= 1'b0;
            mask_q         <= '0;
            core_ack_q     <= '0;
            core_rdata_q   <= '0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            mem_wr_en_q    <= 1'b0;
            access_count_q <= 16'd0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            grant_q        <= grant_d;
            wr_q           <= wr_d;
            mask_q         <= mask_d;
            core_ack_q     <= core_ack_d;
            core_rdata_q   <= core_rdata_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            mem_wr_en_q    <= mem_wr_en_d;
            access_count_q <= access_count_d;
        end
    end

    // A core stalls while its request is outstanding; the ack cycle and the masked cycle read as proceed.
    assign core_status  = rst ? {N_CORES{1'b1}} : ~(core_req & ~core_ack_q & ~mask_q);
    assign core_ack     = core_ack_q;
    assign core_rdata   = core_rdata_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_wr_en    = mem_wr_en_q;
    assign access_count = access_count_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// Scoreboard bench for dram_arbiter: per-core drivers push expected accesses, a negedge
// monitor pops them on every ack and checks read data, RAM contents and core_status.
module tb_dram_arbiter;
    localparam int N     = 4;
    localparam int AW    = 16;
    localparam int DW    = 8;
    localparam int BOUND = 4 * N + 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      core_req = '0;
    logic [N-1:0]      core_wr = '0;
    logic [N*AW-1:0]   core_addr = '0;
    logic [N*DW-1:0]   core_wdata = '0;
    logic [N*DW-1:0]   core_rdata;
    logic [N-1:0]      core_ack;
    logic [N-1:0]      core_status;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic              mem_wr_en;
    logic [DW-1:0]     mem_rdata = '0;
    logic [15:0]       access_count;

    dram_arbiter #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .core_req(core_req), .core_wr(core_wr),
        .core_addr(core_addr), .core_wdata(core_wdata), .core_rdata(core_rdata),
        .core_ack(core_ack), .core_status(core_status), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wr_en(mem_wr_en), .mem_rdata(mem_rdata),
        .access_count(access_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          core;
        bit          wr;
        logic [15:0] addr;
        logic [7:0]  data;
        logic [7:0]  exp_rd;
    } txn_t;

    txn_t        sb[$];
    int          ack_log[$];
    int          ack_cyc[$];
    logic [7:0]  shadow [logic [15:0]];
    logic [7:0]  ram [0:65535];
    bit          written [0:65535];
    logic [N-1:0] pending = '0;
    logic [15:0] exp_count = 16'd0;
    int          cyc = 0;
    int          wr_pulses = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    function automatic logic [7:0] bg(input logic [15:0] a);
        return (a == 16'h0005) ? 8'd35 : 8'(a * 7 + 3);
    endfunction

    function automatic logic [7:0] shadow_rd(input logic [15:0] a);
        return shadow.exists(a) ? shadow[a] : bg(a);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural single-port RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (mem_wr_en) begin
            ram[mem_addr]     <= mem_wdata;
            written[mem_addr] <= 1'b1;
        end
        mem_rdata <= written[mem_addr] ? ram[mem_addr] : bg(mem_addr);
    end

    // Monitor: status rule every cycle, scoreboard pop on every ack.
    always @(negedge clk) begin
        if (rst) begin
            chk("status_in_reset", core_status, {N{1'b1}});
        end else begin
            if (mem_wr_en) wr_pulses++;
            for (int c = 0; c < N; c++)
                chk($sformatf("core_status[%0d]", c), core_status[c], (!pending[c]) || core_ack[c]);
            if (core_ack != '0) begin
                chk("ack_onehot", $onehot(core_ack), 1);
                for (int c = 0; c < N; c++) begin
                    if (core_ack[c]) begin
                        int idx;
                        idx = -1;
                        for (int j = 0; j < sb.size(); j++)
                            if (idx < 0 && sb[j].core == c) idx = j;
                        if (idx < 0) begin
                            n_checks++;
                            n_errors++;
                            $display("FAIL ack_unexpected: got ack on core %0d expected none (cycle %0d)", c, cyc);
                        end else begin
                            if (sb[idx].wr)
                                chk($sformatf("ram_write core%0d", c), ram[sb[idx].addr], sb[idx].data);
                            else
                                chk($sformatf("rdata core%0d", c), core_rdata[c*DW +: DW], sb[idx].exp_rd);
                            sb.delete(idx);
                            pending[c] = 1'b0;
                            ack_log.push_back(c);
                            ack_cyc.push_back(cyc);
                        end
                    end
                end
            end
        end
    end

    task automatic issue(input int c, input bit wr, input logic [15:0] a, input logic [7:0] d);
        txn_t t;
        t.core = c; t.wr = wr; t.addr = a; t.data = d; t.exp_rd = shadow_rd(a);
        if (wr) shadow[a] = d;
        sb.push_back(t);
        pending[c] = 1'b1;
        exp_count++;
        core_wr[c] = wr;
        core_addr[c*AW +: AW] = a;
        core_wdata[c*DW +: DW] = d;
        core_req[c] = 1'b1;
    endtask

    task automatic wait_ack(input int c, input bit drop, output int at);
        at = -1;
        for (int k = 0; k < BOUND; k++) begin
            @(negedge clk);
            if (core_ack[c]) begin
                at = cyc;
                break;
            end
        end
        n_checks++;
        if (at < 0) begin
            n_errors++;
            $display("FAIL ack_timeout: core %0d got no ack, required within %0d cycles", c, BOUND);
        end
        @(posedge clk); #1;
        if (drop) core_req[c] = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        core_req = '0;
        pending = '0;
        exp_count = 16'd0;
        sb.delete();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic core_proc(input int c);
        int at;
        for (int k = 0; k < 10; k++) begin
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #1;
            issue(c, 1'($urandom_range(0, 1)), {4'(c), 9'd0, 3'($urandom_range(0, 7))}, 8'($urandom));
            wait_ack(c, 1'b1, at);
        end
    endtask

    initial begin
        int t0, at, base, w0, a0, a1, a2, a3;
        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_wr_en", mem_wr_en, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_core_ack", core_ack, 0);
        chk("rst_core_rdata", core_rdata, 0);
        chk("rst_access_count", access_count, 0);
        @(posedge clk); #1 rst = 1'b0;

        // Single read by core1, request fields scrambled right after the grant
        @(posedge clk); #1;
        w0 = wr_pulses;
        issue(1, 1'b0, 16'h0005, 8'h00);
        t0 = cyc;
        @(posedge clk); #1;
        core_addr[1*AW +: AW] = 16'h0007;
        core_wr[1] = 1'b1;
        core_wdata[1*DW +: DW] = 8'hEE;
        wait_ack(1, 1'b1, at);
        chk("read_latency", at - t0, 3);
        chk("no_write_after_scramble", wr_pulses - w0, 0);
        @(negedge clk);
        chk("read_rdata_35", core_rdata[1*DW +: DW], 8'd35);
        chk("count_after_one", access_count, 16'd1);

        // Write then read back by core0
        @(posedge clk); #1;
        w0 = wr_pulses;
        issue(0, 1'b1, 16'h0010, 8'hA5);
        wait_ack(0, 1'b1, at);
        chk("single_wr_pulse", wr_pulses - w0, 1);
        @(posedge clk); #1;
        issue(0, 1'b0, 16'h0010, 8'h00);
        wait_ack(0, 1'b1, at);
        @(negedge clk);
        chk("readback_a5", core_rdata[0 +: DW], 8'hA5);

        // All cores at once straight after reset: order 0..3, four cycles apart
        do_reset();
        base = ack_log.size();
        for (int c = 0; c < N; c++) issue(c, 1'b0, {4'(c), 12'h020}, 8'h00);
        t0 = cyc;
        @(negedge clk);
        chk("all_stalled", core_status, 4'h0);
        fork
            wait_ack(0, 1'b1, a0);
            wait_ack(1, 1'b1, a1);
            wait_ack(2, 1'b1, a2);
            wait_ack(3, 1'b1, a3);
        join
        chk("all_ack_count", ack_log.size() - base, N);
        if (ack_log.size() - base == N) begin
            for (int i = 0; i < N; i++) begin
                chk($sformatf("rr_order[%0d]", i), ack_log[base + i], i);
                if (i > 0) chk($sformatf("rr_spacing[%0d]", i), ack_cyc[base + i] - ack_cyc[base + i - 1], 4);
            end
            chk("all_served_bound", (ack_cyc[base + N - 1] - t0) <= 4 * N, 1);
        end

        // Fairness: core0 keeps its request high while core2 waits
        @(posedge clk); #1;
        base = ack_log.size();
        issue(0, 1'b0, 16'h0003, 8'h00);
        issue(2, 1'b0, 16'h2001, 8'h00);
        fork
            begin
                wait_ack(0, 1'b0, a0);
                @(posedge clk); #1;
                issue(0, 1'b0, 16'h0004, 8'h00);
                wait_ack(0, 1'b1, a1);
            end
            wait_ack(2, 1'b1, a2);
        join
        chk("fair_ack_count", ack_log.size() - base, 3);
        if (ack_log.size() - base == 3) begin
            chk("fair_order0", ack_log[base], 0);
            chk("fair_order1", ack_log[base + 1], 2);
            chk("fair_order2", ack_log[base + 2], 0);
        end

        // Randomized traffic, each core in its own address region
        fork
            core_proc(0);
            core_proc(1);
            core_proc(2);
            core_proc(3);
        join
        @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        chk("count_total", access_count, exp_count);

        // Reset during CAPTURE of a read abandons it
        do_reset();
        @(posedge clk); #1;
        core_wr[3] = 1'b0;
        core_addr[3*AW +: AW] = 16'h0005;
        pending[3] = 1'b1;
        core_req[3] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        core_req[3] = 1'b0;
        pending[3] = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("abandon_ack", core_ack, 0);
            chk("abandon_rdata", core_rdata, 0);
            chk("abandon_count", access_count, 0);
        end
        @(posedge clk); #1;
        issue(1, 1'b0, 16'h0005, 8'h00);
        wait_ack(1, 1'b1, at);
        @(negedge clk);
        chk("after_abandon_count", access_count, 16'd1);

        // Counter wrap from 16'hFFFF
        @(posedge clk); #1;
        force dut.access_count_q = 16'hFFFF;
        @(posedge clk); #1;
        release dut.access_count_q;
        @(negedge clk);
        chk("count_preload", access_count, 16'hFFFF);
        @(posedge clk); #1;
        issue(2, 1'b0, 16'h2002, 8'h00);
        wait_ack(2, 1'b1, at);
        @(negedge clk);
        chk("count_wrap", access_count, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1);
    end

endmodule
